// File: rtl/export_fifo_pkg.sv
// Shared types and helpers for the exported-method result FIFO.
// Startup state encoding and count-width helper.
package export_fifo_pkg;

  localparam int DEFAULT_STARTUP_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_STARTUP,
    ST_LIVE
  } startup_t;

  function automatic int clog2_plus1(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/export_fifo_storage.sv
// Result FIFO storage: one write port, async read port.
// Contents are intentionally not reset.
module export_fifo_storage
  import export_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/export_result_fifo.sv
// Show-ahead result FIFO feeding the host mailbox reader.
// Watermark stats enabled by KANAGAWA_RESULT_FIFO_STATS_EN.
module export_result_fifo
  import export_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int ALMOST_FULL_LEVEL = 12,
  parameter int STARTUP_CYCLES = DEFAULT_STARTUP_CYCLES,
  localparam int CW = clog2_plus1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             rst_and_startup_done_out,
  input  logic             wren_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             almost_full_out,
  input  logic             rden_in,
  output logic             empty_out,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    count_out,
  output logic             overflow_out,
  output logic             underflow_out,
  output logic [CW-1:0]    max_count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARTUP_CYCLES + 1);

  startup_t        state, state_nx;
  logic [SW-1:0]   scnt, scnt_nx;
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count, count_nx;
  logic            live, full, empty_c;
  logic            do_wr, do_pop;
  logic            af_q, ovf_q, unf_q;

  always_comb begin
    state_nx = state;
    scnt_nx  = scnt;
    unique case (state)
      ST_RESET: begin
        if (STARTUP_CYCLES == 1) begin
          state_nx = ST_LIVE;
        end else begin
          state_nx = ST_STARTUP;
          scnt_nx  = SW'(1);
        end
      end
      ST_STARTUP: begin
        if (scnt == SW'(STARTUP_CYCLES - 1))
          state_nx = ST_LIVE;
        else
          scnt_nx = scnt + SW'(1);
      end
      ST_LIVE: ;
      default: state_nx = ST_RESET;
    endcase
  end

  assign live    = (state == ST_LIVE);
  assign full    = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign do_pop  = live & rden_in & ~empty_c;
  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign do_wr   = live & wren_in & (~full | do_pop);

  always_comb begin
    count_nx = count;
    if (do_wr & ~do_pop)
      count_nx = count + CW'(1);
    else if (~do_wr & do_pop)
      count_nx = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RESET;
      scnt  <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      af_q  <= 1'b1;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state <= state_nx;
      scnt  <= scnt_nx;
      count <= count_nx;
      if (do_wr) wptr <= wptr + PW'(1);
      if (do_pop) rptr <= rptr + PW'(1);
      af_q <= (state_nx == ST_LIVE)
            ? (count_nx >= CW'(ALMOST_FULL_LEVEL))
            : 1'b1;
      if (live & wren_in & full & ~do_pop) ovf_q <= 1'b1;
      if (live & rden_in & empty_c) unf_q <= 1'b1;
    end
  end

  export_fifo_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wptr),
    .wdata (data_in),
    .raddr (rptr),
    .rdata (data_out)
  );

`ifdef KANAGAWA_RESULT_FIFO_STATS_EN
  logic [CW-1:0] max_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      max_q <= '0;
    else if (count > max_q)
      max_q <= count;
  end

  assign max_count_out = max_q;
`else
  assign max_count_out = '0;
`endif

  assign rst_and_startup_done_out = live;
  assign almost_full_out = af_q;
  assign empty_out       = empty_c;
  assign count_out       = count;
  assign overflow_out    = ovf_q;
  assign underflow_out   = unf_q;

endmodule

// File: doc/export_result_fifo.md
Name: export_result_fifo

Overview:
- Callee-side result buffer for an exported method: the transmitter end of the FIFO-read protocol (rden / empty / data) that the host-side mailbox reader drains.
- Accepts results from the method pipeline on a write port with almost-full backpressure.
- Presents them show-ahead on the read port.
- Owns the startup-done indication for that interface.

Parameters:
- WIDTH, 32, result payload width in bits.
- DEPTH, 16, entries; power of two, >= 4.
- ALMOST_FULL_LEVEL, 12, almost_full_out asserts when count_out >= this value; range 1..DEPTH.
- STARTUP_CYCLES, 4, cycles after reset release before the interface is live; >= 1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low; 0 = in reset.
- rst_and_startup_done_out  out  1  interface live.
- wren_in  in  1  pipeline write strobe.
- data_in  in  WIDTH  pipeline result.
- almost_full_out  out  1  backpressure to pipeline.
- rden_in  in  1  host pop request.
- empty_out  out  1  no entry presented.
- data_out  out  WIDTH  head entry; valid while empty_out=0.
- count_out  out  $clog2(DEPTH)+1  current occupancy.
- overflow_out  out  1  sticky: write dropped.
- underflow_out  out  1  sticky: pop while empty.
- max_count_out  out  $clog2(DEPTH)+1  high-watermark (optional feature).

Behaviour:
Reset (rst=0, async):
- Pointers and count_out = 0; empty_out = 1; almost_full_out = 1; overflow_out = underflow_out = 0; rst_and_startup_done_out = 0; max_count_out = 0.
- data_out = don't care.
- Storage contents are not reset.

Startup FSM: RESET -> STARTUP -> LIVE.
- On rst release, STARTUP counts STARTUP_CYCLES clocks.
- Then LIVE: rst_and_startup_done_out = 1, almost_full_out follows occupancy.
- Outside LIVE, wren_in and rden_in are ignored and flags are not set.
- Reset asserted in any state returns to RESET immediately.
- Reset mid-operation discards all entries.

Write path:
- wren_in=1 in LIVE stores data_in at the write pointer.
- The entry is visible next cycle: empty_out falls at N+1 for a write at N into an empty FIFO.

Read path (show-ahead):
- data_out is a combinational mux of the head entry.
- rden_in=1 with empty_out=0 pops at that edge; the next entry, or empty_out=1, appears the following cycle.
- No read latency; back-to-back pops every cycle are legal.

Boundaries:
- Write when count_out=DEPTH and no valid pop in the same cycle: write dropped, overflow_out set.
- Write when full with a valid pop in the same cycle: both take effect, count unchanged.
- rden_in while empty_out=1: no pop, underflow_out set. A simultaneous write still succeeds and becomes visible next cycle (no bypass).
- Simultaneous valid write and pop otherwise: count unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from count_out, not pointer equality.

Flags:
- almost_full_out is registered from next-count.
- overflow_out and underflow_out clear only on reset.

Optional Feature:
- Macro: KANAGAWA_RESULT_FIFO_STATS_EN.
- Defined: max_count_out holds the highest count_out reached since reset; it updates the cycle after count_out changes.
- Undefined: max_count_out is tied to 0 and no watermark register is instantiated.

Decomposition:
- Shared package export_fifo_pkg:
  - count-width function clog2_plus1.
  - localparam default STARTUP_CYCLES.
  - typedef enum for startup states {ST_RESET, ST_STARTUP, ST_LIVE}.
- One sub-module, export_fifo_storage: register array with one write port and an asynchronous read port indexed by the read pointer.
- Pointers, count, flags and FSM stay in the top module.

Test Plan:
- Reset then startup: hold rst=0 for 10 cycles, release -> rst_and_startup_done_out rises exactly 4 cycles later; almost_full_out=1 until then; wren_in=1 during STARTUP stores nothing (count_out=0).
- Ordered drain: write 0,5,10,...,45 on 10 consecutive cycles, then pop continuously -> data_out sequence 0..45 step 5; empty_out=1 after the tenth pop; count_out returns to 0.
- Backpressure: write 12 entries -> almost_full_out=1 the cycle after the 12th write; pop 1 -> almost_full_out=0 the next cycle.
- Full boundary: fill 16, write 0xDEAD with no pop -> overflow_out=1, count_out=16, 0xDEAD absent. Fill 16, then write 0xBEEF with a simultaneous pop -> count_out=16, 0xBEEF is the last entry drained.
- Empty boundary: pop while empty together with a write of 7 -> underflow_out=1; the next cycle empty_out=0 and data_out=7.
- Wrap and reset: stream 40 entries with random rden_in -> in-order data across 2+ pointer wraps. Assert rst mid-stream with 5 entries held -> empty_out=1 and count_out=0 immediately. With KANAGAWA_RESULT_FIFO_STATS_EN defined, max_count_out equals the peak occupancy reached before the reset and is 0 after it.
